cbd_poly_buf: RTL and testbench
===============================

CBD_POLY_BUF -- requirements
Module: cbd_poly_buf

Interface
REQ-001 Parameter N, 256, polynomial length in coefficients.
REQ-002 Parameter LANES, 16, coefficients per input beat.
REQ-003 Parameter Q, 3329, Kyber modulus.
REQ-004 i_clk  in  1  clock; all logic on rising edge.
REQ-005 i_rstn  in  1  reset; asynchronous, active-low.
REQ-006 i_coeffs  in  48  16 x 3-bit two's-complement CBD coefficients; lane 0 in [47:45], lane 15 in [2:0].
REQ-007 i_coeffs_valid  in  1  i_coeffs holds a valid beat.
REQ-008 o_coeffs_ready  out  1  the block accepts a beat this cycle.
REQ-009 o_coef  out  12  one coefficient reduced into [0, Q-1].
REQ-010 o_coef_idx  out  8  polynomial index of o_coef.
REQ-011 o_coef_valid  out  1  o_coef and o_coef_idx are valid.
REQ-012 i_coef_ready  in  1  the downstream consumer accepts o_coef.
REQ-013 o_done  out  1  one-cycle pulse after the last coefficient is transferred.
REQ-014 o_err  out  1  sticky flag; a lane carried 3'b100.

Function
REQ-015 A beat transfers when i_coeffs_valid and o_coeffs_ready are both 1; a coefficient transfers when o_coef_valid and i_coef_ready are both 1.
REQ-016 The FSM SHALL have states S_IDLE, S_FILL, S_DRAIN and S_DONE.
REQ-017 S_IDLE: o_coeffs_ready=1. On the first beat transfer, go to S_FILL and store that beat as beat 0.
REQ-018 S_FILL: o_coeffs_ready=1. Beat k (0..15) is written to buffer indices 16k..16k+15, with lane j at index 16k+j.
REQ-019 A 4-bit beat counter SHALL increment on each beat transfer. On the transfer of beat 15, the counter wraps to 0 and the state goes to S_DRAIN.
REQ-020 S_DRAIN: o_coeffs_ready=0. Input beats are neither stored nor counted; stalling upstream is the upstream's job.
REQ-021 Reduction is done on write. A lane c >= 0 is stored as c. A lane c < 0 is stored as Q+c: -1 -> 3328, -2 -> 3327, -3 -> 3326.
REQ-022 A lane equal to 3'b100 is stored as 3325 and sets o_err. o_err stays set until reset.
REQ-023 In S_DRAIN, o_coef_valid=1 and o_coef = buf[idx], with an 8-bit idx starting at 0. The first o_coef_valid comes one cycle after the beat-15 transfer.
REQ-024 idx SHALL increment only on a coefficient transfer. o_coef and o_coef_idx SHALL hold stable while i_coef_ready=0.
REQ-025 On the transfer at idx=255, idx wraps to 0 and the state goes to S_DONE.
REQ-026 S_DONE lasts exactly one cycle: o_done=1, o_coef_valid=0, o_coeffs_ready=0. Next state is S_IDLE.
REQ-027 Throughput is 16 fill cycles plus 256 drain cycles, plus one cycle for S_DONE, when there are no stalls.
REQ-028 i_coeffs_valid may drop between beats in S_FILL. The beat counter holds, and no partial-polynomial timeout exists.

Reset
REQ-029 Asserting i_rstn low, at any time including mid-fill or mid-drain, forces the following immediately, and the partial polynomial is discarded:
- state = S_IDLE, beat counter = 0, idx = 0;
- o_coef_valid = 0, o_done = 0, o_err = 0, o_coef = 0, o_coef_idx = 0;
- o_coeffs_ready = 0 while reset is held.
REQ-030 Buffer contents need no reset, and no stale value may reach o_coef before it has been rewritten.

Structure
REQ-031 The shared configs package SHALL hold KYBER_Q=3329, KYBER_N=256, and the CBD beat width of 48.
REQ-032 Sub-module cbd_modq3 SHALL map one 3-bit coefficient to its 12-bit residue plus an error bit; it is instantiated LANES times.
REQ-033 The buffer SHALL be implemented as N x 12 registers, written 16-wide and read 1-wide; no RAM macro.

Verification
REQ-034 16 consecutive beats of all lanes 3'b001, then hold i_coef_ready=1:
- o_coef=1 for idx 0..255;
- o_done pulses one cycle after idx 255 transfers;
- total time 273 cycles.
REQ-035 Beat 0 = {3'b111, 3'b110, 3'b101, 3'b011, 12 x 3'b000}:
- idx0=3328, idx1=3327, idx2=3326, idx3=3;
- idx4..15=0;
- o_err stays 0.
REQ-036 One lane = 3'b100 in beat 7 -> that index reads 3325, and o_err=1 persists after o_done.
REQ-037 Toggle i_coef_ready randomly during drain, and drive i_coeffs_valid=1 throughout drain:
- o_coef and o_coef_idx stay stable while stalled;
- no index is skipped;
- extra beats are ignored, and the next polynomial starts only after S_DONE.
REQ-038 Assert i_rstn low after 9 beats, then send 16 fresh beats -> the output equals the fresh data only, with idx starting at 0.

Source files
------------

// File: rtl/cbd_poly_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cbd_poly_buf_pkg
// Description : Shared Kyber configuration constants and the state encoding
//               for the CBD polynomial buffer.
//               KYBER_Q    - Kyber modulus
//               KYBER_N    - polynomial length in coefficients
//               CBD_BEAT_W - width of one CBD input beat
//               CBD_COEF_W - width of one CBD coefficient lane
//               COEF_W     - width of one reduced coefficient
// Revision    : 1.0 - initial release
// ============================================================================
package cbd_poly_buf_pkg;

    localparam int KYBER_Q    = 3329;
    localparam int KYBER_N    = 256;
    localparam int CBD_BEAT_W = 48;
    localparam int CBD_COEF_W = 3;
    localparam int CBD_LANES  = CBD_BEAT_W / CBD_COEF_W;
    localparam int COEF_W     = 12;

    // Buffer FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_FILL  = 2'd1;
    localparam state_t S_DRAIN = 2'd2;
    localparam state_t S_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/cbd_modq3.sv
`default_nettype none
// ============================================================================
// Module      : cbd_modq3
// Description : Maps one 3-bit two's-complement CBD coefficient to its
//               residue in [0, Q-1]. A negative value c becomes Q+c, which
//               for a 3-bit pattern equals (Q-8) + unsigned(pattern).
//               The pattern 3'b100 (-4) is outside the CBD range; it still
//               maps through the same formula (Q-4) and raises err.
// Ports       : cbd     in  3   two's-complement coefficient
//               residue out 12  reduced coefficient
//               err     out 1   cbd was 3'b100
// Revision    : 1.0 - initial release
// ============================================================================
module cbd_modq3
    import cbd_poly_buf_pkg::*;
#(
    parameter int Q = KYBER_Q
) (
    input  logic [CBD_COEF_W-1:0] cbd,
    output logic [COEF_W-1:0]     residue,
    output logic                  err
);

    localparam logic [COEF_W-1:0] c_neg_base = COEF_W'(Q - 8);

    always_comb begin
        if (cbd[CBD_COEF_W-1]) begin
            residue = c_neg_base + {{(COEF_W-CBD_COEF_W){1'b0}}, cbd};
        end else begin
            residue = {{(COEF_W-CBD_COEF_W){1'b0}}, cbd};
        end
        err = (cbd == 3'b100);
    end

endmodule
`default_nettype wire

// File: rtl/cbd_poly_buf.sv
`default_nettype none
// ============================================================================
// Module      : cbd_poly_buf
// Description : Collects one polynomial of CBD coefficients arriving LANES
//               per beat, reduces every lane into [0, Q-1] as it is written,
//               then streams the polynomial out one coefficient per transfer
//               in index order, followed by a one-cycle done pulse.
// Ports       : i_clk          in  1         clock, rising edge
//               i_rstn         in  1         async active-low reset
//               i_coeffs       in  3*LANES   beat, lane 0 in the top bits
//               i_coeffs_valid in  1         beat valid
//               o_coeffs_ready out 1         beat accepted this cycle
//               o_coef         out 12        reduced coefficient
//               o_coef_idx     out log2(N)   index of o_coef
//               o_coef_valid   out 1         o_coef/o_coef_idx valid
//               i_coef_ready   in  1         consumer accepts o_coef
//               o_done         out 1         pulse after last coefficient
//               o_err          out 1         sticky, a lane carried 3'b100
// Revision    : 1.0 - initial release
// ============================================================================
module cbd_poly_buf
    import cbd_poly_buf_pkg::*;
#(
    parameter int N     = KYBER_N,
    parameter int LANES = CBD_LANES,
    parameter int Q     = KYBER_Q
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic [CBD_COEF_W*LANES-1:0]   i_coeffs,
    input  logic                          i_coeffs_valid,
    output logic                          o_coeffs_ready,
    output logic [COEF_W-1:0]             o_coef,
    output logic [$clog2(N)-1:0]          o_coef_idx,
    output logic                          o_coef_valid,
    input  logic                          i_coef_ready,
    output logic                          o_done,
    output logic                          o_err
);

    localparam int IDX_W  = $clog2(N);
    localparam int BEATS  = N / LANES;
    localparam int BEAT_W = $clog2(BEATS);

    localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(BEATS - 1);
    localparam logic [IDX_W-1:0]  c_last_idx  = IDX_W'(N - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BEAT_W-1:0]  r_beat_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_err;

    logic               w_beat_xfer;
    logic               w_coef_xfer;

    logic [COEF_W-1:0]  w_res      [LANES];
    logic [LANES-1:0]   w_lane_err;

    logic [COEF_W-1:0]  r_buf      [N];

    assign w_beat_xfer = i_coeffs_valid & o_coeffs_ready;
    assign w_coef_xfer = o_coef_valid & i_coef_ready;

    // ------------------------------------------------------------------
    // Per-lane reduction; lane 0 sits in the most significant bits.
    // ------------------------------------------------------------------
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        cbd_modq3 #(
            .Q (Q)
        ) u_modq3 (
            .cbd     (i_coeffs[CBD_COEF_W*(LANES-1-j) +: CBD_COEF_W]),
            .residue (w_res[j]),
            .err     (w_lane_err[j])
        );
    end

    // ------------------------------------------------------------------
    // Coefficient register file. Each entry knows statically which beat
    // and lane feed it, so the write side is just an enable compare.
    // No reset: every entry is rewritten before the drain can read it.
    // ------------------------------------------------------------------
    for (genvar e = 0; e < N; e++) begin : g_buf
        localparam int c_beat = e / LANES;
        localparam int c_lane = e % LANES;

        always_ff @(posedge i_clk) begin
            if (w_beat_xfer && (r_beat_cnt == BEAT_W'(c_beat))) begin
                r_buf[e] <= w_res[c_lane];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_beat_xfer) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (w_beat_xfer && (r_beat_cnt == c_last_beat)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_coef_xfer && (r_idx == c_last_idx)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Ready is gated by the reset pin so that it drops the
    // moment reset is asserted, not at the next clock.
    // ------------------------------------------------------------------
    always_comb begin
        o_coeffs_ready = 1'b0;
        o_coef_valid   = 1'b0;
        o_done         = 1'b0;
        case (r_state)
            S_IDLE,
            S_FILL:  o_coeffs_ready = i_rstn;
            S_DRAIN: o_coef_valid   = 1'b1;
            S_DONE:  o_done         = 1'b1;
            default: o_done         = 1'b0;
        endcase
        o_coef = o_coef_valid ? r_buf[r_idx] : '0;
    end

    assign o_coef_idx = r_idx;
    assign o_err      = r_err;

    // ------------------------------------------------------------------
    // Beat counter: advances on every accepted beat, wraps after the last
    // beat of the polynomial; holds across upstream bubbles.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_beat_cnt <= '0;
        end else if (w_beat_xfer) begin
            if (r_beat_cnt == c_last_beat) begin
                r_beat_cnt <= '0;
            end else begin
                r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Drain index: advances only on an accepted coefficient, so output
    // data and index hold while the consumer stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_idx <= '0;
        end else if (w_coef_xfer) begin
            if (r_idx == c_last_idx) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky error: only lanes of beats actually accepted count.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_err <= 1'b0;
        end else if (w_beat_xfer && (|w_lane_err)) begin
            r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cbd_poly_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_cbd_poly_buf
// Description : Directed scoreboard bench for cbd_poly_buf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cbd_poly_buf;
    import cbd_poly_buf_pkg::*;

    typedef struct packed {
        logic [11:0] coef;
        logic [7:0]  idx;
    } exp_t;

    typedef logic [47:0] poly_t [16];

    logic        clk;
    logic        i_rstn;
    logic [47:0] i_coeffs;
    logic        i_coeffs_valid;
    logic        o_coeffs_ready;
    logic [11:0] o_coef;
    logic [7:0]  o_coef_idx;
    logic        o_coef_valid;
    logic        i_coef_ready;
    logic        o_done;
    logic        o_err;

    cbd_poly_buf dut (
        .i_clk          (clk),
        .i_rstn         (i_rstn),
        .i_coeffs       (i_coeffs),
        .i_coeffs_valid (i_coeffs_valid),
        .o_coeffs_ready (o_coeffs_ready),
        .o_coef         (o_coef),
        .o_coef_idx     (o_coef_idx),
        .o_coef_valid   (o_coef_valid),
        .i_coef_ready   (i_coef_ready),
        .o_done         (o_done),
        .o_err          (o_err)
    );

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   done_cnt    = 0;
    int   done_cyc    = 0;
    int   first_cyc   = 0;
    bit   rnd_ready   = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_mod(input logic [2:0] c);
        case (c)
            3'b000:  return 12'd0;
            3'b001:  return 12'd1;
            3'b010:  return 12'd2;
            3'b011:  return 12'd3;
            3'b100:  return 12'd3325;
            3'b101:  return 12'd3326;
            3'b110:  return 12'd3327;
            default: return 12'd3328;
        endcase
    endfunction

    function automatic logic [47:0] rnd_beat();
        logic [47:0] b;
        logic [2:0]  l;
        for (int j = 0; j < 16; j++) begin
            l = 3'($urandom_range(0, 7));
            if (l == 3'b100) l = 3'b000;
            b[3*(15-j) +: 3] = l;
        end
        return b;
    endfunction

    // Downstream ready: always 1, or random while rnd_ready is set
    initial begin
        i_coef_ready = 1'b1;
        forever begin
            @(negedge clk);
            i_coef_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: sampled 1 time unit after the falling edge
    initial begin
        bit   done_exp;
        exp_t e;
        done_exp = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!i_rstn) begin
                done_exp = 1'b0;
            end else begin
                if (done_exp) begin
                    check("done_pulse", 32'(o_done), 32'd1);
                    check("done_valid_low", 32'(o_coef_valid), 32'd0);
                    done_exp = 1'b0;
                end else if (o_done) begin
                    check("done_spurious", 32'(o_done), 32'd0);
                end
                if (o_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (o_coef_valid) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 32'(sb.size()), 32'd1);
                    end else if (i_coef_ready) begin
                        e = sb.pop_front();
                        check("coef", 32'(o_coef), 32'(e.coef));
                        check("idx", 32'(o_coef_idx), 32'(e.idx));
                        if (e.idx == 8'd255) done_exp = 1'b1;
                    end else begin
                        check("stall_coef", 32'(o_coef), 32'(sb[0].coef));
                        check("stall_idx", 32'(o_coef_idx), 32'(sb[0].idx));
                    end
                end
            end
        end
    end

    // Present nbeats beats of p; each beat is pushed to the scoreboard
    // once ready is seen, i.e. just before the edge that accepts it.
    task automatic send_poly(input poly_t p, input bit gaps, input bit hold, input int nbeats);
        int w;
        for (int k = 0; k < nbeats; k++) begin
            @(negedge clk);
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                i_coeffs_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            i_coeffs_valid = 1'b1;
            i_coeffs       = p[k];
            w = 0;
            while (!o_coeffs_ready && w < 2000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 2000) check("ready_timeout", 32'(o_coeffs_ready), 32'd1);
            if (k == 0) first_cyc = cyc;
            for (int j = 0; j < 16; j++) begin
                sb.push_back('{coef: ref_mod(p[k][3*(15-j) +: 3]), idx: 8'(16*k + j)});
            end
        end
        @(negedge clk);
        if (!hold) i_coeffs_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int w;
        w = 0;
        while (done_cnt < target && w < 3000) begin
            @(negedge clk);
            w++;
        end
        i_coeffs_valid = 1'b0;
        check("done_seen", 32'(done_cnt), 32'(target));
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", 32'(o_coeffs_ready), 32'd0);
        check("rst_valid", 32'(o_coef_valid), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_coef", 32'(o_coef), 32'd0);
        check("rst_idx", 32'(o_coef_idx), 32'd0);
    endtask

    initial begin
        poly_t p;
        poly_t p2;

        i_rstn         = 1'b1;
        i_coeffs       = '0;
        i_coeffs_valid = 1'b0;
        #1 i_rstn = 1'b0;
        #2 check_reset_outputs();
        repeat (2) @(negedge clk);
        i_rstn = 1'b1;
        @(negedge clk);
        #1 check("idle_ready", 32'(o_coeffs_ready), 32'd1);

        // All lanes +1, back-to-back, consumer always ready
        for (int k = 0; k < 16; k++) p[k] = 48'h249249249249;
        send_poly(p, 1'b0, 1'b0, 16);
        wait_done(1);
        check("latency", 32'(done_cyc - first_cyc + 1), 32'd273);

        // Negative lanes in beat 0, bubbles between beats
        p[0] = {3'b111, 3'b110, 3'b101, 3'b011, 36'd0};
        for (int k = 1; k < 16; k++) p[k] = rnd_beat();
        send_poly(p, 1'b1, 1'b0, 16);
        wait_done(2);
        check("err_clean", 32'(o_err), 32'd0);

        // Illegal -4 in beat 7 lane 5 -> index 117
        for (int k = 0; k < 16; k++) p[k] = rnd_beat();
        p[7][3*(15-5) +: 3] = 3'b100;
        send_poly(p, 1'b0, 1'b0, 16);
        wait_done(3);
        #1 check("err_set", 32'(o_err), 32'd1);
        repeat (3) @(negedge clk);
        #1 check("err_sticky", 32'(o_err), 32'd1);

        // Random consumer stalls, upstream valid held through drain,
        // second polynomial queued behind the first
        rnd_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            p[k]  = rnd_beat();
            p2[k] = rnd_beat();
        end
        send_poly(p, 1'b0, 1'b1, 16);
        send_poly(p2, 1'b0, 1'b1, 16);
        wait_done(5);
        rnd_ready = 1'b0;

        // Reset after 9 beats, then a fresh polynomial
        for (int k = 0; k < 16; k++) p[k] = rnd_beat();
        send_poly(p, 1'b0, 1'b0, 9);
        i_rstn = 1'b0;
        #1 check_reset_outputs();
        sb.delete();
        repeat (2) @(negedge clk);
        i_rstn = 1'b1;
        for (int k = 0; k < 16; k++) p[k] = rnd_beat();
        send_poly(p, 1'b1, 1'b0, 16);
        wait_done(6);
        check("err_after_rst", 32'(o_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
